// File: rtl/y86_pkg.sv
// Shared constants for the Y86 pipeline controller: instruction codes, status
// codes, the register-none marker and the control FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_HLT    = 3'd2;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [2:0] S_INS    = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } ctl_state_e;

endpackage

// File: rtl/y86_perf_cnt.sv
// Three free-running wrap-around performance counters, each advancing by one
// on a cycle where its enable is high.
module y86_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cyc_en,
    input  logic             ret_en,
    input  logic             stall_en,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        cyc_d   = cyc_q + CNT_W'(cyc_en);
        ret_d   = ret_q + CNT_W'(ret_en);
        stall_d = stall_q + CNT_W'(stall_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q   <= '0;
            ret_q   <= '0;
            stall_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            stall_q <= stall_d;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign ret_cnt   = ret_q;
    assign stall_cnt = stall_q;

endmodule

// File: rtl/y86_pipe_ctl.sv
// Y86 five-stage pipeline control: per-stage stall/bubble generation, memory
// wait-state handshake with timeout, run/halt FSM and performance counters.
module y86_pipe_ctl
    import y86_pkg::*;
#(
    parameter int unsigned ID_W        = 8,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ID_W-1:0]  D_icode,
    input  logic [ID_W-1:0]  d_srcA,
    input  logic [ID_W-1:0]  d_srcB,
    input  logic [ID_W-1:0]  E_icode,
    input  logic [ID_W-1:0]  E_dstM,
    input  logic             e_Cnd,
    input  logic [ID_W-1:0]  M_icode,
    input  logic [2:0]       m_stat,
    input  logic [ID_W-1:0]  W_icode,
    input  logic [2:0]       W_stat,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_bubble,
    output logic             mem_fault,
    output logic [2:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT - 1);

    ctl_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    logic [2:0]        stat_q, stat_d;
    logic              halted_q, halted_d;

    logic loaduse, mispred, ret_haz, m_exc, w_exc, timeout;
    logic f_st, d_st, e_st, m_st, w_st, d_bb, e_bb, m_bb, w_bb;

    always_comb begin
        loaduse = (E_icode == ID_W'(I_MRMOVL) || E_icode == ID_W'(I_POPL))
                  && E_dstM != ID_W'(RNONE)
                  && (E_dstM == d_srcA || E_dstM == d_srcB);
        mispred = (E_icode == ID_W'(I_JXX)) && !e_Cnd;
        ret_haz = (D_icode == ID_W'(I_RET)) || (E_icode == ID_W'(I_RET))
                  || (M_icode == ID_W'(I_RET));
        m_exc   = (m_stat != S_AOK);
        w_exc   = (W_stat != S_AOK);
        // wait_q holds the number of mem_ready-low cycles already seen
        timeout = (state_q == ST_MEMWAIT) && !mem_ready && (wait_q >= WAIT_LIM);
    end

    always_comb begin
        f_st = 1'b0; d_st = 1'b0; e_st = 1'b0; m_st = 1'b0; w_st = 1'b0;
        d_bb = 1'b0; e_bb = 1'b0; m_bb = 1'b0; w_bb = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                f_st = loaduse | ret_haz;
                d_st = loaduse;
                d_bb = mispred | (ret_haz & !loaduse);
                e_bb = mispred | loaduse;
                m_bb = m_exc | w_exc;
                w_st = w_exc;
            end
            ST_MEMWAIT: begin
                f_st = 1'b1; d_st = 1'b1; e_st = 1'b1; m_st = 1'b1;
                w_bb = 1'b1;
            end
            ST_DRAIN: begin
                f_st = 1'b1; d_st = 1'b1; e_st = 1'b1;
                m_bb = 1'b1;
            end
            ST_HALTED: begin
                f_st = 1'b1; d_st = 1'b1; e_st = 1'b1; m_st = 1'b1; w_st = 1'b1;
            end
            default: ;
        endcase
        // A stage in reset never holds or flushes; stall wins over bubble.
        F_stall  = rst & f_st;
        D_stall  = rst & d_st;
        E_stall  = rst & e_st;
        M_stall  = rst & m_st;
        W_stall  = rst & w_st;
        D_bubble = rst & d_bb & !d_st;
        E_bubble = rst & e_bb & !e_st;
        M_bubble = rst & m_bb & !m_st;
        W_bubble = rst & w_bb & !w_st;
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = 1'b0;
        stat_d  = stat_q;
        unique case (state_q)
            ST_RUN: begin
                if (w_exc) begin
                    state_d = ST_HALTED;
                    stat_d  = W_stat;
                end else if (mem_req && !mem_ready) begin
                    state_d = ST_MEMWAIT;
                    wait_d  = WAIT_W'(1);
                end else if (m_exc || fault_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_MEMWAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (timeout) begin
                    state_d = ST_DRAIN;
                    wait_d  = '0;
                    fault_d = 1'b1;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (w_exc) begin
                    state_d = ST_HALTED;
                    stat_d  = W_stat;
                end
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            wait_q   <= '0;
            fault_q  <= 1'b0;
            stat_q   <= S_AOK;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            fault_q  <= fault_d;
            stat_q   <= stat_d;
            halted_q <= halted_d;
        end
    end

    assign mem_fault = fault_q;
    assign cpu_stat  = stat_q;
    assign halted    = halted_q;

    y86_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .cyc_en    (state_q != ST_HALTED),
        .ret_en    (W_icode != ID_W'(I_NOP) && !W_stall && W_stat == S_AOK),
        .stall_en  (state_q == ST_MEMWAIT),
        .cyc_cnt   (cyc_cnt),
        .ret_cnt   (ret_cnt),
        .stall_cnt (stall_cnt)
    );

endmodule

// File: tb/tb_y86_pipe_ctl.sv
// Self-checking bench for y86_pipe_ctl: directed hazard/memory/halt scenarios
// plus a randomized phase, all compared against a behavioural model.
module tb_y86_pipe_ctl;

    localparam int unsigned ID_W  = 8;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned TMO   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ID_W-1:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic e_Cnd, mem_req, mem_ready;
    logic [2:0] m_stat, W_stat;
    logic F_stall, D_stall, E_stall, M_stall, W_stall;
    logic D_bubble, E_bubble, M_bubble, W_bubble;
    logic mem_fault, halted;
    logic [2:0] cpu_stat;
    logic [CNT_W-1:0] cyc_cnt, ret_cnt, stall_cnt;

    always #5 clk = ~clk;

    y86_pipe_ctl #(.ID_W(ID_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat),
        .W_icode(W_icode), .W_stat(W_stat),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall),
        .M_stall(M_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .W_bubble(W_bubble), .mem_fault(mem_fault), .cpu_stat(cpu_stat),
        .halted(halted), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
        .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: processor mode as flags plus count of low-ready cycles.
    bit               halted_m, waiting_m, draining_m, fault_m;
    int unsigned      low_m;
    logic [2:0]       stat_m;
    logic [CNT_W-1:0] cyc_m, ret_m, stl_m;
    logic [CNT_W-1:0] snap;

    initial begin
        #1_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [CNT_W-1:0] obs,
                       input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {F,D,E,M,W stall, D,E,M,W bubble}
    function automatic logic [8:0] exp_ctl();
        bit lu, mp, rt;
        if (!rst)      return 9'b00000_0000;
        if (halted_m)  return 9'b11111_0000;
        if (waiting_m) return 9'b11110_0001;
        if (draining_m) return 9'b11100_0010;
        lu = (E_icode == 5 || E_icode == 11) && E_dstM != 15
             && (E_dstM == d_srcA || E_dstM == d_srcB);
        mp = (E_icode == 7) && !e_Cnd;
        rt = (D_icode == 9) || (E_icode == 9) || (M_icode == 9);
        return {lu | rt, lu, 1'b0, 1'b0, W_stat != 3'd1,
                mp | (rt && !lu), mp | lu,
                (m_stat != 3'd1) || (W_stat != 3'd1), 1'b0};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".ctl"}, CNT_W'({F_stall, D_stall, E_stall, M_stall, W_stall,
                                   D_bubble, E_bubble, M_bubble, W_bubble}),
            CNT_W'(exp_ctl()));
        chk({tag, ".fault"}, CNT_W'(mem_fault), CNT_W'(fault_m));
        chk({tag, ".stat"}, CNT_W'(cpu_stat), CNT_W'(stat_m));
        chk({tag, ".halted"}, CNT_W'(halted), CNT_W'(halted_m));
        chk({tag, ".cyc"}, cyc_cnt, cyc_m);
        chk({tag, ".ret"}, ret_cnt, ret_m);
        chk({tag, ".stl"}, stall_cnt, stl_m);
    endtask

    task automatic model_edge();
        logic [8:0] c;
        bit nf;
        c  = exp_ctl();
        nf = 1'b0;
        if (W_icode != 1 && !c[4] && W_stat == 3'd1) ret_m++;
        if (!halted_m) cyc_m++;
        if (waiting_m) stl_m++;
        if (halted_m) begin
        end else if (waiting_m) begin
            if (mem_ready) waiting_m = 1'b0;
            else begin
                low_m++;
                if (low_m >= TMO) begin
                    waiting_m = 1'b0; draining_m = 1'b1; nf = 1'b1;
                end
            end
        end else if (draining_m) begin
            if (W_stat != 3'd1) begin
                draining_m = 1'b0; halted_m = 1'b1; stat_m = W_stat;
            end
        end else if (W_stat != 3'd1) begin
            halted_m = 1'b1; stat_m = W_stat;
        end else if (mem_req && !mem_ready) begin
            waiting_m = 1'b1; low_m = 1;
        end else if (m_stat != 3'd1 || fault_m) begin
            draining_m = 1'b1;
        end
        fault_m = nf;
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        D_icode = 8'd1; E_icode = 8'd1; M_icode = 8'd1; W_icode = 8'd1;
        d_srcA = 8'h0F; d_srcB = 8'h0F; E_dstM = 8'h0F; e_Cnd = 1'b1;
        m_stat = 3'd1; W_stat = 3'd1; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases on a negedge.
    task automatic do_reset();
        #2 rst = 1'b0;
        halted_m = 0; waiting_m = 0; draining_m = 0; fault_m = 0; low_m = 0;
        stat_m = 3'd1; cyc_m = '0; ret_m = '0; stl_m = '0;
        #1 check_all("rst_async");
        idle();
        @(negedge clk);
        check_all("rst_hold");
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        idle();
        do_reset();
        step("idle");

        // load/use: mrmovl to %eax in E, addl reading %eax in D
        E_icode = 8'd5; E_dstM = 8'd0; d_srcA = 8'd0; D_icode = 8'd6;
        step("loaduse");
        idle(); E_icode = 8'd6; W_icode = 8'd5;
        step("loaduse_after");
        idle(); E_icode = 8'd5; E_dstM = 8'h0F; d_srcA = 8'h0F;
        step("loaduse_rnone");

        // mispredicted and correctly predicted branch
        idle(); E_icode = 8'd7; e_Cnd = 1'b0;
        step("mispred");
        e_Cnd = 1'b1; W_icode = 8'd6;
        step("jxx_taken");

        // ret travelling through D, E, M, then ret with a load/use
        idle(); D_icode = 8'd9;                step("ret_d");
        idle(); E_icode = 8'd9;                step("ret_e");
        idle(); M_icode = 8'd9;                step("ret_m");
        idle();                                step("ret_gone");
        D_icode = 8'd9; E_icode = 8'd11; E_dstM = 8'd3; d_srcB = 8'd3;
        step("ret_loaduse");

        // five low-ready cycles: no fault, five stalled cycles
        idle(); W_icode = 8'd6;
        snap = stall_cnt;
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (5) step("memwait");
        mem_ready = 1'b1;
        step("memwait_done");
        chk("memwait5.delta", stall_cnt - snap, CNT_W'(5));
        idle();
        step("after_wait");

        // randomized traffic, statuses kept AOK
        for (int i = 0; i < 300; i++) begin
            D_icode   = ID_W'($urandom_range(0, 11));
            E_icode   = ID_W'($urandom_range(0, 11));
            M_icode   = ID_W'($urandom_range(0, 11));
            W_icode   = ID_W'($urandom_range(0, 11));
            d_srcA    = ID_W'($urandom_range(0, 15));
            d_srcB    = ID_W'($urandom_range(0, 15));
            E_dstM    = ID_W'($urandom_range(0, 15));
            e_Cnd     = 1'($urandom_range(0, 1));
            mem_req   = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            step("rand");
        end

        // reset asserted in the middle of a memory wait
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) step("pre_rst_wait");
        do_reset();
        step("post_rst");

        // memory timeout -> fault -> drain -> halt with ADR
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        repeat (TMO) step("tmo_wait");
        idle();
        step("tmo_fault");
        step("tmo_drain");
        W_stat = 3'd3;
        step("tmo_wadr");
        idle();
        chk("tmo.halted", CNT_W'(halted), CNT_W'(1));
        chk("tmo.stat", CNT_W'(cpu_stat), CNT_W'(3));
        W_icode = 8'd6; D_icode = 8'd9; E_icode = 8'd7; e_Cnd = 1'b0;
        repeat (3) step("tmo_halted");

        // halt reaching writeback from RUN
        idle();
        do_reset();
        W_icode = 8'd0; W_stat = 3'd2;
        step("whlt");
        idle();
        chk("whlt.stat", CNT_W'(cpu_stat), CNT_W'(2));
        snap = cyc_cnt;
        repeat (4) step("whlt_frozen");
        chk("whlt.cyc_frozen", cyc_cnt - snap, CNT_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
